// File: rtl/alpu_pipe_sched.sv
// Issue scheduler / pipeline sequencer for the 3-stage piped ALPU: round-robin issue,
// shadow valid/id/tag tracking, result handshake. Optional perf counters: ALPU_SCHED_PERF_EN.
module alpu_pipe_sched #(
    parameter int unsigned REG_WIDTH = 16,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned TAG_WIDTH = 4,
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*REG_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*REG_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*8-1:0]           req_ctrl,
    input  logic [NUM_REQ-1:0]             req_cin,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
    output logic [REG_WIDTH-1:0]           alpu_a,
    output logic [REG_WIDTH-1:0]           alpu_b,
    output logic [7:0]                     alpu_ctrl,
    output logic                           alpu_cin,
    output logic                           alpu_pipe_active,
    output logic                           alpu_reset_n,
    input  logic [REG_WIDTH-1:0]           alpu_out,
    input  logic                           alpu_cout,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [REG_WIDTH-1:0]           res_data,
    output logic                           res_cout,
    output logic [ID_W-1:0]                res_id,
    output logic [TAG_WIDTH-1:0]           res_tag
`ifdef ALPU_SCHED_PERF_EN
    ,
    output logic [31:0]                    perf_issued,
    output logic [31:0]                    perf_stall_cycles,
    output logic [31:0]                    perf_bubbles
`endif
);

    logic                 v0_q, v1_q, v2_q, v0_d, v1_d, v2_d;
    logic [ID_W-1:0]      id0_q, id1_q, id2_q, id0_d, id1_d, id2_d;
    logic [TAG_WIDTH-1:0] tag0_q, tag1_q, tag2_q, tag0_d, tag1_d, tag2_d;
    logic [ID_W-1:0]      rr_q, rr_d;

    logic                 stall;
    logic                 can_issue;
    logic                 issue;
    logic [ID_W-1:0]      gnt_id;
    logic [TAG_WIDTH-1:0] gnt_tag;
    logic [ID_W-1:0]      rr_adv;
    int unsigned          p;

    // First valid requester at or after rr_q (with wrap) wins; its fields drive the ALPU.
    always_comb begin
        stall     = v2_q & ~res_ready;
        can_issue = ~stall & ~flush & ~reset;
        issue     = 1'b0;
        gnt_id    = '0;
        gnt_tag   = '0;
        rr_adv    = rr_q;
        req_ready = '0;
        alpu_a    = '0;
        alpu_b    = '0;
        alpu_ctrl = '0;
        alpu_cin  = 1'b0;
        p         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            p = 32'(rr_q) + i;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (can_issue && !issue && req_valid[p]) begin
                issue        = 1'b1;
                gnt_id       = ID_W'(p);
                gnt_tag      = req_tag[p*TAG_WIDTH +: TAG_WIDTH];
                req_ready[p] = 1'b1;
                alpu_a       = req_a[p*REG_WIDTH +: REG_WIDTH];
                alpu_b       = req_b[p*REG_WIDTH +: REG_WIDTH];
                alpu_ctrl    = req_ctrl[p*8 +: 8];
                alpu_cin     = req_cin[p];
                rr_adv       = (p + 1 == NUM_REQ) ? '0 : ID_W'(p + 1);
            end
        end
    end

    always_comb begin
        v0_d   = v0_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        id0_d  = id0_q;
        id1_d  = id1_q;
        id2_d  = id2_q;
        tag0_d = tag0_q;
        tag1_d = tag1_q;
        tag2_d = tag2_q;
        rr_d   = rr_q;
        if (flush) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else if (!stall) begin
            v0_d   = issue;
            v1_d   = v0_q;
            v2_d   = v1_q;
            id0_d  = issue ? gnt_id : '0;
            id1_d  = id0_q;
            id2_d  = id1_q;
            tag0_d = issue ? gnt_tag : '0;
            tag1_d = tag0_q;
            tag2_d = tag1_q;
        end
        if (issue) rr_d = rr_adv;
    end

`ifdef ALPU_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q, perf_bubbles_q;
    logic [31:0] perf_issued_d, perf_stall_d, perf_bubbles_d;

    always_comb begin
        perf_issued_d  = perf_issued_q + 32'(issue);
        perf_stall_d   = perf_stall_q + 32'(stall);
        perf_bubbles_d = perf_bubbles_q + 32'(~v2_q & ~stall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q  <= '0;
            perf_stall_q   <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_stall_q   <= perf_stall_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_issued       = perf_issued_q;
    assign perf_stall_cycles = perf_stall_q;
    assign perf_bubbles      = perf_bubbles_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            id0_q  <= '0;
            id1_q  <= '0;
            id2_q  <= '0;
            tag0_q <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            rr_q   <= '0;
        end else begin
            v0_q   <= v0_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            id0_q  <= id0_d;
            id1_q  <= id1_d;
            id2_q  <= id2_d;
            tag0_q <= tag0_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            rr_q   <= rr_d;
        end
    end

    // Result side is forced to zero while reset is asserted, independent of ALPU contents.
    assign alpu_pipe_active = ~stall | reset;
    assign alpu_reset_n     = ~reset;
    assign res_valid        = v2_q & ~reset;
    assign res_data         = reset ? '0 : alpu_out;
    assign res_cout         = reset ? 1'b0 : alpu_cout;
    assign res_id           = reset ? '0 : id2_q;
    assign res_tag          = reset ? '0 : tag2_q;

endmodule

// File: tb/tb_alpu_pipe_sched.sv
// Directed self-checking bench for alpu_pipe_sched with a 3-stage ALPU stand-in
// (ctrl 0x00 = add with carry, ctrl 0x01 = xor).
module tb_alpu_pipe_sched;
    logic        clk = 1'b0;
    logic        reset, flush, res_ready;
    logic [1:0]  req_valid, req_ready, req_cin;
    logic [31:0] req_a, req_b;
    logic [15:0] req_ctrl;
    logic [7:0]  req_tag;
    logic [15:0] alpu_a, alpu_b, alpu_out, res_data;
    logic [7:0]  alpu_ctrl;
    logic        alpu_cin, alpu_pipe_active, alpu_reset_n, alpu_cout;
    logic        res_valid, res_cout;
    logic [0:0]  res_id;
    logic [3:0]  res_tag;
`ifdef ALPU_SCHED_PERF_EN
    logic [31:0] perf_issued, perf_stall_cycles, perf_bubbles;
`endif
    int passes = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alpu_pipe_sched #(.REG_WIDTH(16), .NUM_REQ(2), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_cin(req_cin), .req_tag(req_tag),
        .alpu_a(alpu_a), .alpu_b(alpu_b), .alpu_ctrl(alpu_ctrl), .alpu_cin(alpu_cin),
        .alpu_pipe_active(alpu_pipe_active), .alpu_reset_n(alpu_reset_n),
        .alpu_out(alpu_out), .alpu_cout(alpu_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_id(res_id), .res_tag(res_tag)
`ifdef ALPU_SCHED_PERF_EN
        , .perf_issued(perf_issued), .perf_stall_cycles(perf_stall_cycles),
        .perf_bubbles(perf_bubbles)
`endif
    );

    // ALPU stand-in: three enabled register stages, synchronous active-low reset.
    logic [16:0] s0, s1, s2;
    logic [16:0] f_res;
    always_comb begin
        if (alpu_ctrl == 8'h01) f_res = {1'b0, alpu_a ^ alpu_b};
        else                    f_res = {1'b0, alpu_a} + {1'b0, alpu_b} + {16'd0, alpu_cin};
    end
    always @(posedge clk) begin
        if (!alpu_reset_n) begin
            s0 <= '0; s1 <= '0; s2 <= '0;
        end else if (alpu_pipe_active) begin
            s0 <= f_res; s1 <= s0; s2 <= s1;
        end
    end
    assign alpu_out  = s2[15:0];
    assign alpu_cout = s2[16];

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; flush = 1'b0; req_valid = '0; res_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; req_valid = 2'b11; res_ready = 1'b0;
        req_a = '0; req_b = '0; req_ctrl = '0; req_cin = '0; req_tag = '0;
        tick; #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b want 00", req_ready); else passes++;
        checks++; if (res_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", res_valid); else passes++;
        checks++; if (alpu_pipe_active !== 1'b1) $display("FAIL rst_active: got %b want 1", alpu_pipe_active); else passes++;
        checks++; if (alpu_reset_n !== 1'b0) $display("FAIL rst_reset_n: got %b want 0", alpu_reset_n); else passes++;
        checks++; if (res_data !== 16'h0 || res_tag !== 4'h0) $display("FAIL rst_data: got %h/%h want 0/0", res_data, res_tag); else passes++;
        req_valid = '0; reset = 1'b0; #1;
        checks++; if (alpu_reset_n !== 1'b1) $display("FAIL rst_release: got %b want 1", alpu_reset_n); else passes++;
    endtask

    task automatic test_single;
        req_a[15:0] = 16'h0003; req_b[15:0] = 16'h0004; req_ctrl[7:0] = 8'h00;
        req_cin[0] = 1'b0; req_tag[3:0] = 4'h5; req_valid = 2'b01; res_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL single_grant: got %b want 01", req_ready); else passes++;
        tick; req_valid = '0; #1;
        checks++; if (res_valid !== 1'b0) $display("FAIL single_lat1: got %b want 0", res_valid); else passes++;
        tick;
        checks++; if (res_valid !== 1'b0) $display("FAIL single_lat2: got %b want 0", res_valid); else passes++;
        tick;
        checks++; if (res_valid !== 1'b1) $display("FAIL single_lat3: got %b want 1", res_valid); else passes++;
        checks++; if (res_data !== 16'h0007 || res_cout !== 1'b0) $display("FAIL single_data: got %h/%b want 0007/0", res_data, res_cout); else passes++;
        checks++; if (res_id !== 1'b0 || res_tag !== 4'h5) $display("FAIL single_idtag: got %0d/%h want 0/5", res_id, res_tag); else passes++;
        tick;
        checks++; if (res_valid !== 1'b0) $display("FAIL single_drop: got %b want 0", res_valid); else passes++;
    endtask

    task automatic test_round_robin;
        logic [15:0] exp_data [4] = '{16'h0011, 16'h0033, 16'h0011, 16'h0033};
        logic [3:0]  exp_tag  [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        logic [1:0]  exp_gnt;
        int r;
        do_reset;
        req_a = {16'h003C, 16'h0010}; req_b = {16'h000F, 16'h0001};
        req_ctrl = {8'h01, 8'h00}; req_cin = 2'b00; req_tag = {4'h2, 4'h1};
        res_ready = 1'b1; req_valid = 2'b11;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                #1; exp_gnt = (c % 2 == 1) ? 2'b10 : 2'b01;
                checks++; if (req_ready !== exp_gnt) $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, exp_gnt); else passes++;
            end
            tick;
            if (c < 4) begin
                if (c % 2 == 0) req_tag[3:0] = req_tag[3:0] + 4'd2;
                else            req_tag[7:4] = req_tag[7:4] + 4'd2;
                if (c == 3) req_valid = '0;
            end
            #1; r = c - 2;
            if (r >= 0 && r < 4) begin
                checks++;
                if (res_valid !== 1'b1 || res_id !== 1'(r % 2) || res_tag !== exp_tag[r] || res_data !== exp_data[r])
                    $display("FAIL rr_res%0d: got v%b id%0d tag%h data%h want v1 id%0d tag%h data%h",
                             r, res_valid, res_id, res_tag, res_data, r % 2, exp_tag[r], exp_data[r]);
                else passes++;
            end else begin
                checks++; if (res_valid !== 1'b0) $display("FAIL rr_idle%0d: got %b want 0", c, res_valid); else passes++;
            end
        end
    endtask

    task automatic test_stall;
        logic [15:0] exp_data [3] = '{16'h0011, 16'h0012, 16'h0013};
        logic [3:0]  exp_tag  [3] = '{4'h7, 4'h8, 4'h9};
        do_reset;
        req_b[15:0] = 16'h0010; req_ctrl[7:0] = 8'h00; req_cin = '0;
        res_ready = 1'b0; req_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            req_a[15:0] = 16'(c + 1); req_tag[3:0] = 4'(7 + c);
            tick;
        end
        req_a[15:0] = 16'h0004; req_tag[3:0] = 4'hA;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick;
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== 16'h0011 || res_tag !== 4'h7 || alpu_pipe_active !== 1'b0 || req_ready !== 2'b00)
                $display("FAIL stall_hold%0d: got v%b data%h tag%h act%b rdy%b want v1 data0011 tag7 act0 rdy00",
                         k, res_valid, res_data, res_tag, alpu_pipe_active, req_ready);
            else passes++;
        end
        res_ready = 1'b1; req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_data[k] || res_tag !== exp_tag[k])
                $display("FAIL stall_drain%0d: got v%b data%h tag%h want v1 data%h tag%h",
                         k, res_valid, res_data, res_tag, exp_data[k], exp_tag[k]);
            else passes++;
            tick;
        end
        checks++; if (res_valid !== 1'b0) $display("FAIL stall_end: got %b want 0", res_valid); else passes++;
    endtask

    task automatic test_flush;
        do_reset;
        req_b[15:0] = 16'h0010; req_ctrl[7:0] = 8'h00; req_cin = '0;
        res_ready = 1'b1; req_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            req_a[15:0] = 16'(c + 1); req_tag[3:0] = 4'(1 + c);
            tick;
        end
        req_a[15:0] = 16'h0020; req_tag[3:0] = 4'hA; flush = 1'b1; #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL flush_block: got %b want 00", req_ready); else passes++;
        tick;
        flush = 1'b0; req_a[15:0] = 16'h0005; req_b[15:0] = 16'h0006; req_tag[3:0] = 4'hB; #1;
        checks++; if (res_valid !== 1'b0) $display("FAIL flush_drop: got %b want 0", res_valid); else passes++;
        checks++; if (req_ready !== 2'b01) $display("FAIL flush_regrant: got %b want 01", req_ready); else passes++;
        tick; req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (res_valid !== 1'b0) $display("FAIL flush_ghost%0d: got v%b tag%h want v0", k, res_valid, res_tag); else passes++;
            tick;
        end
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h000B || res_tag !== 4'hB || res_id !== 1'b0)
            $display("FAIL flush_new: got v%b data%h tag%h id%0d want v1 data000B tagB id0", res_valid, res_data, res_tag, res_id);
        else passes++;
        tick;
        checks++; if (res_valid !== 1'b0) $display("FAIL flush_new_end: got %b want 0", res_valid); else passes++;
    endtask

    task automatic test_reset_mid;
        req_a = {16'h0200, 16'h0100}; req_b = {16'h0002, 16'h0001};
        req_ctrl = '0; req_cin = '0; req_tag = {4'hD, 4'hC};
        res_ready = 1'b1; req_valid = 2'b11; #1;
        checks++; if (req_ready !== 2'b10) $display("FAIL rmid_grant_a: got %b want 10", req_ready); else passes++;
        tick; #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL rmid_grant_b: got %b want 01", req_ready); else passes++;
        tick;
        reset = 1'b1; #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL rmid_ready: got %b want 00", req_ready); else passes++;
        tick; #1;
        checks++;
        if (res_valid !== 1'b0 || alpu_pipe_active !== 1'b1 || alpu_reset_n !== 1'b0 || res_data !== 16'h0 || res_tag !== 4'h0 || res_id !== 1'b0)
            $display("FAIL rmid_outs: got v%b act%b rn%b data%h tag%h id%0d want v0 act1 rn0 data0000 tag0 id0",
                     res_valid, alpu_pipe_active, alpu_reset_n, res_data, res_tag, res_id);
        else passes++;
        reset = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL rmid_restart: got %b want 01", req_ready); else passes++;
        tick; req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (res_valid !== 1'b0) $display("FAIL rmid_stale%0d: got v%b tag%h want v0", k, res_valid, res_tag); else passes++;
            tick;
        end
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0101 || res_tag !== 4'hC || res_id !== 1'b0)
            $display("FAIL rmid_first: got v%b data%h tag%h id%0d want v1 data0101 tagC id0", res_valid, res_data, res_tag, res_id);
        else passes++;
    endtask

`ifdef ALPU_SCHED_PERF_EN
    task automatic test_perf;
        int issued;
        do_reset;
        checks++;
        if (perf_issued !== 32'd0 || perf_stall_cycles !== 32'd0 || perf_bubbles !== 32'd0)
            $display("FAIL perf_clear: got %0d/%0d/%0d want 0/0/0", perf_issued, perf_stall_cycles, perf_bubbles);
        else passes++;
        req_a[15:0] = 16'h0001; req_b[15:0] = 16'h0001; req_ctrl = '0; req_tag = '0;
        issued = 0;
        for (int c = 0; c < 20; c++) begin
            res_ready = (c == 5 || c == 6) ? 1'b0 : 1'b1;
            req_valid = (issued < 10) ? 2'b01 : 2'b00;
            #1;
            if (req_ready[0]) issued++;
            tick;
        end
        checks++; if (perf_issued !== 32'd10) $display("FAIL perf_issued: got %0d want 10", perf_issued); else passes++;
        checks++; if (perf_stall_cycles !== 32'd2) $display("FAIL perf_stall: got %0d want 2", perf_stall_cycles); else passes++;
        checks++; if (perf_bubbles !== 32'd8) $display("FAIL perf_bubbles: got %0d want 8", perf_bubbles); else passes++;
        reset = 1'b1; tick; reset = 1'b0; #1;
        checks++;
        if (perf_issued !== 32'd0 || perf_stall_cycles !== 32'd0 || perf_bubbles !== 32'd0)
            $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", perf_issued, perf_stall_cycles, perf_bubbles);
        else passes++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_round_robin;
        test_stall;
        test_flush;
        test_reset_mid;
`ifdef ALPU_SCHED_PERF_EN
        test_perf;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
